hazard_ctrl_mc: RTL and testbench

//  Next-generation hazard controller for the 5-stage RV32I pipeline: stall/flush/forward control plus cache-miss

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/fwd_sel.sv | 30 +++
 rtl/hazard_ctrl_mc.sv | 201 ++++++++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller.
//   hz_state_e  : controller FSM state (RUN, LU, IMISS, DMISS)
//   stage_vec_t : one bit per pipeline stage (F, D, E, M, W), used for the
//                 stall and flush bundles
//   FWD_*       : operand-select codes driven on Forward1E / Forward2E
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LU    = 2'd1,
    IMISS = 2'd2,
    DMISS = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
    logic w;
  } stage_vec_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one E-stage source operand.
//   rs_used : source operand is actually read by the instruction in E
//   rs      : source register number in E
//   rd_m/wr_m, rd_w/wr_w : destination register and write-enable of M and W
//   sel     : FWD_M when M holds the newest value, else FWD_W, else FWD_REG
// x0 is never forwarded; M wins when both M and W match.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              rs_used,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              wr_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              wr_w,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_REG;
    if (rs_used && wr_m && (rd_m != '0) && (rs == rd_m)) begin
      sel = FWD_M;
    end else if (rs_used && wr_w && (rd_w != '0) && (rs == rd_w)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RV32I pipeline.
// Drives per-stage stall/flush and the E-stage forwarding selects, and tracks
// cache misses, multi-cycle load-use bubbles and redirects that land while an
// instruction fetch miss is outstanding.
//   CPU_CLK, CPU_RST_N          : clock, asynchronous active-low reset
//   ICacheMiss, DCacheMiss      : outstanding miss levels
//   BranchE, JalrE, JalD        : redirect in E, jal decoded in D
//   Rs*/Rd*, RegRead*, RegWrite*, MemToRegE : pipeline register metadata
//   Stall*/Flush*               : per-stage hold / clear
//   Forward1E, Forward2E        : E operand source (M, W or register file)
//   StallCycles                 : saturating count of cycles with StallF=1
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST_N,
  input  logic              ICacheMiss,
  input  logic              DCacheMiss,
  input  logic              BranchE,
  input  logic              JalrE,
  input  logic              JalD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        RegReadD,
  input  logic [1:0]        RegReadE,
  input  logic [2:0]        RegWriteE,
  input  logic [2:0]        RegWriteM,
  input  logic [2:0]        RegWriteW,
  input  logic              MemToRegE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushF,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        Forward1E,
  output logic [1:0]        Forward2E,
  output logic [CNT_W-1:0]  StallCycles
);

  // Extra bubbles still owed after the detection cycle.
  localparam logic [1:0]       LU_INIT = 2'(LU_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // True when rd is a real register that the D-stage instruction reads.
  function automatic logic src_hit(input logic [1:0]        used,
                                   input logic [REG_AW-1:0] rs1,
                                   input logic [REG_AW-1:0] rs2,
                                   input logic [REG_AW-1:0] rd);
    return (rd != '0) && ((used[1] && (rd == rs1)) || (used[0] && (rd == rs2)));
  endfunction

  hz_state_e        state_q, state_d;
  logic [1:0]       lu_cnt_q, lu_cnt_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  stage_vec_t stall_v, flush_v, stall_o, flush_o;
  logic [1:0] fwd1_sel, fwd2_sel;

  logic redirect, load_use, raw_any, interlock, lu_active;

  assign redirect  = BranchE | JalrE;
  assign load_use  = MemToRegE && src_hit(RegReadD, Rs1D, Rs2D, RdE);
  assign raw_any   = ((|RegWriteE) && src_hit(RegReadD, Rs1D, Rs2D, RdE)) ||
                     ((|RegWriteM) && src_hit(RegReadD, Rs1D, Rs2D, RdM)) ||
                     ((|RegWriteW) && src_hit(RegReadD, Rs1D, Rs2D, RdW));
  assign interlock = !FWD_EN && raw_any;
  // A countdown interrupted by a data miss picks up again once the miss clears.
  assign lu_active = (state_q == LU) || ((state_q == DMISS) && (lu_cnt_q != 2'd0));

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    redir_pend_d = redir_pend_q;
    stall_v      = '0;
    flush_v      = '0;

    if (DCacheMiss) begin
      // Freeze the whole pipe; countdown and pending redirect are kept.
      stall_v = '1;
      state_d = DMISS;
    end else if (redirect) begin
      flush_v.d    = 1'b1;
      flush_v.e    = 1'b1;
      lu_cnt_d     = 2'd0;
      redir_pend_d = ICacheMiss;
      state_d      = RUN;
    end else if (lu_active || load_use || interlock) begin
      stall_v.f = 1'b1;
      stall_v.d = 1'b1;
      flush_v.e = 1'b1;
      if (lu_active) begin
        lu_cnt_d = lu_cnt_q - 2'd1;
      end else if (load_use) begin
        lu_cnt_d = LU_INIT;
      end
      state_d = (lu_cnt_d != 2'd0) ? LU : RUN;
    end else begin
      if (ICacheMiss) begin
        // Hold the PC and feed a bubble into D while the line is fetched.
        stall_v.f = 1'b1;
        flush_v.d = 1'b1;
        state_d   = IMISS;
      end else begin
        flush_v.d = JalD;
        state_d   = RUN;
      end
      // The fetch in flight at redirect time is from the old path: keep D
      // flushed until that miss returns, and drop its result once more.
      if (redir_pend_q) begin
        flush_v.d = 1'b1;
        if (!ICacheMiss) begin
          redir_pend_d = 1'b0;
        end
      end
    end
  end

  // Outputs are a pure function of state and inputs, so holding reset low
  // forces the flush-everything pattern without waiting for a clock.
  assign stall_o = CPU_RST_N ? stall_v : '0;
  assign flush_o = CPU_RST_N ? flush_v : '1;

  assign StallF = stall_o.f;
  assign StallD = stall_o.d;
  assign StallE = stall_o.e;
  assign StallM = stall_o.m;
  assign StallW = stall_o.w;
  assign FlushF = flush_o.f;
  assign FlushD = flush_o.d;
  assign FlushE = flush_o.e;
  assign FlushM = flush_o.m;
  assign FlushW = flush_o.w;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_o.f && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q        <= RUN;
      lu_cnt_q       <= 2'd0;
      redir_pend_q   <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      lu_cnt_q       <= lu_cnt_d;
      redir_pend_q   <= redir_pend_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign StallCycles = stall_cycles_q;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd1 (
    .rs_used (RegReadE[1]),
    .rs      (Rs1E),
    .rd_m    (RdM),
    .wr_m    (|RegWriteM),
    .rd_w    (RdW),
    .wr_w    (|RegWriteW),
    .sel     (fwd1_sel)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd2 (
    .rs_used (RegReadE[0]),
    .rs      (Rs2E),
    .rd_m    (RdM),
    .wr_m    (|RegWriteM),
    .rd_w    (RdW),
    .wr_w    (|RegWriteW),
    .sel     (fwd2_sel)
  );

  // Interlock mode never forwards: operands always come from the register file.
  assign Forward1E = (FWD_EN && CPU_RST_N) ? fwd1_sel : FWD_REG;
  assign Forward2E = (FWD_EN && CPU_RST_N) ? fwd2_sel : FWD_REG;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc. Two instances share all inputs:
//   dut_a : forwarding, LU_BUBBLES=2, CNT_W=8
//   dut_b : interlock (FWD_EN=0), LU_BUBBLES=1, CNT_W=8
// Inputs change on the falling edge; expected values are queued with the
// stimulus and compared 2 ns later, well clear of the rising edge.
module tb_hazard_ctrl_mc;

  localparam int AW = 5;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MemToRegE;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    RegReadD, RegReadE;
  logic [2:0]    RegWriteE, RegWriteM, RegWriteW;

  logic          a_sf, a_sd, a_se, a_sm, a_sw, a_ff, a_fd, a_fe, a_fm, a_fw;
  logic [1:0]    a_f1, a_f2;
  logic [CW-1:0] a_cnt;
  logic          b_sf, b_sd, b_se, b_sm, b_sw, b_ff, b_fd, b_fe, b_fm, b_fw;
  logic [1:0]    b_f1, b_f2;
  logic [CW-1:0] b_cnt;

  hazard_ctrl_mc #(.REG_AW(AW), .FWD_EN(1'b1), .LU_BUBBLES(2), .CNT_W(CW)) dut_a (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegReadD(RegReadD), .RegReadE(RegReadE),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm), .StallW(a_sw),
    .FlushF(a_ff), .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm), .FlushW(a_fw),
    .Forward1E(a_f1), .Forward2E(a_f2), .StallCycles(a_cnt)
  );

  hazard_ctrl_mc #(.REG_AW(AW), .FWD_EN(1'b0), .LU_BUBBLES(1), .CNT_W(CW)) dut_b (
    .CPU_CLK(clk), .CPU_RST_N(rst_n), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegReadD(RegReadD), .RegReadE(RegReadE),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm), .StallW(b_sw),
    .FlushF(b_ff), .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm), .FlushW(b_fw),
    .Forward1E(b_f1), .Forward2E(b_f2), .StallCycles(b_cnt)
  );

  // Stage masks, bit order F D E M W.
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_F    = 5'b10000;
  localparam logic [4:0] S_FD   = 5'b11000;
  localparam logic [4:0] S_ALL  = 5'b11111;
  localparam logic [4:0] FL_D   = 5'b01000;
  localparam logic [4:0] FL_E   = 5'b00100;
  localparam logic [4:0] FL_DE  = 5'b01100;
  localparam logic [4:0] FL_ALL = 5'b11111;

  typedef enum logic [1:0] {K_CTL_A, K_CTL_B, K_CNT_A} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [13:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  function automatic logic [13:0] ctl(input logic [4:0] s, input logic [4:0] f,
                                      input logic [1:0] f1, input logic [1:0] f2);
    return {s, f, f1, f2};
  endfunction

  task automatic push(input string tag, input kind_e k, input logic [13:0] v);
    sb_t e;
    e.tag  = tag;
    e.kind = k;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic push_cnt(input string tag, input logic [CW-1:0] v);
    push(tag, K_CNT_A, {6'd0, v});
  endtask

  // Pop every queued expectation and compare with what the DUTs show now.
  task automatic check();
    sb_t         e;
    logic [13:0] obs;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_CTL_A: obs = {a_sf, a_sd, a_se, a_sm, a_sw, a_ff, a_fd, a_fe, a_fm, a_fw, a_f1, a_f2};
        K_CTL_B: obs = {b_sf, b_sd, b_se, b_sm, b_sw, b_ff, b_fd, b_fe, b_fm, b_fw, b_f1, b_f2};
        default: obs = {6'd0, a_cnt};
      endcase
      n_checks++;
      assert (obs === e.exp) else begin
        n_errors++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic clear_inputs();
    ICacheMiss = 1'b0; DCacheMiss = 1'b0; BranchE = 1'b0; JalrE = 1'b0; JalD = 1'b0;
    MemToRegE = 1'b0;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegReadD = 2'b00; RegReadE = 2'b00;
    RegWriteE = 3'd0; RegWriteM = 3'd0; RegWriteW = 3'd0;
  endtask

  task automatic next();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic settle();
    #2;
    check();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Load in E writing x5, D reads x5 as rs1.
  task automatic drive_load_use();
    MemToRegE = 1'b1; RdE = 5'd5; RegWriteE = 3'd1; Rs1D = 5'd5; RegReadD = 2'b10;
  endtask

  initial begin
    clear_inputs();

    // ---- reset held low: flush everything, no stall, no forwarding ----
    next();
    RegReadE = 2'b11; Rs1E = 5'd7; RdM = 5'd7; RegWriteM = 3'd1;
    push("reset_ctl_a", K_CTL_A, ctl(S_NONE, FL_ALL, 2'b00, 2'b00));
    push("reset_ctl_b", K_CTL_B, ctl(S_NONE, FL_ALL, 2'b00, 2'b00));
    push_cnt("reset_cnt", 8'd0);
    settle();

    next();
    rst_n = 1'b1;
    push("idle_after_reset", K_CTL_A, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    // ---- forwarding ----
    next();
    RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; RegWriteM = 3'd1; RegWriteW = 3'd1; RegReadE = 2'b10;
    push("fwd_m_wins", K_CTL_A, ctl(S_NONE, S_NONE, 2'b10, 2'b00));
    push("interlock_no_fwd", K_CTL_B, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    next();
    RdM = 5'd0; RdW = 5'd7; Rs1E = 5'd7; RegWriteM = 3'd1; RegWriteW = 3'd1; RegReadE = 2'b10;
    push("fwd_w_rdm0", K_CTL_A, ctl(S_NONE, S_NONE, 2'b01, 2'b00));
    settle();

    next();
    RegWriteM = 3'd1; RegWriteW = 3'd1; RegReadE = 2'b11;
    push("fwd_x0_never", K_CTL_A, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    next();
    Rs2E = 5'd9; RdM = 5'd9; RegWriteM = 3'd0; RdW = 5'd9; RegWriteW = 3'd4; RegReadE = 2'b01;
    push("fwd2_m_not_writing", K_CTL_A, ctl(S_NONE, S_NONE, 2'b00, 2'b01));
    settle();

    next();
    Rs2E = 5'd9; RdM = 5'd9; RegWriteM = 3'd2; RegReadE = 2'b10;
    push("fwd2_unused_src", K_CTL_A, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    // ---- load-use with two bubbles ----
    next();
    drive_load_use();
    push("lu_detect", K_CTL_A, ctl(S_FD, FL_E, 2'b00, 2'b00));
    settle();

    next();
    RdM = 5'd5; RegWriteM = 3'd1; Rs1D = 5'd5; RegReadD = 2'b10;
    push("lu_second_bubble", K_CTL_A, ctl(S_FD, FL_E, 2'b00, 2'b00));
    settle();

    next();
    RdW = 5'd5; RegWriteW = 3'd1; Rs1E = 5'd5; RegReadE = 2'b10;
    push("lu_done_fwd_w", K_CTL_A, ctl(S_NONE, S_NONE, 2'b01, 2'b00));
    settle();

    // ---- data miss in the middle of a load-use countdown ----
    next();
    drive_load_use();
    push("lu_before_dmiss", K_CTL_A, ctl(S_FD, FL_E, 2'b00, 2'b00));
    settle();

    for (int i = 0; i < 5; i++) begin
      next();
      DCacheMiss = 1'b1;
      BranchE    = (i == 2);
      push($sformatf("dmiss_freeze_%0d", i), K_CTL_A, ctl(S_ALL, S_NONE, 2'b00, 2'b00));
      settle();
    end

    next();
    push("lu_resumes", K_CTL_A, ctl(S_FD, FL_E, 2'b00, 2'b00));
    settle();

    next();
    push("lu_resume_done", K_CTL_A, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    // ---- branch redirect during an I-miss ----
    next();
    BranchE = 1'b1; ICacheMiss = 1'b1;
    push("redir_cycle", K_CTL_A, ctl(S_NONE, FL_DE, 2'b00, 2'b00));
    settle();

    for (int i = 0; i < 3; i++) begin
      next();
      ICacheMiss = 1'b1;
      push($sformatf("redir_imiss_%0d", i), K_CTL_A, ctl(S_F, FL_D, 2'b00, 2'b00));
      settle();
    end

    next();
    push("redir_release_flush", K_CTL_A, ctl(S_NONE, FL_D, 2'b00, 2'b00));
    settle();

    next();
    push("redir_pend_cleared", K_CTL_A, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    // ---- redirect aborts a load-use countdown ----
    next();
    drive_load_use();
    push("abort_lu_detect", K_CTL_A, ctl(S_FD, FL_E, 2'b00, 2'b00));
    settle();

    next();
    JalrE = 1'b1;
    push("abort_jalr", K_CTL_A, ctl(S_NONE, FL_DE, 2'b00, 2'b00));
    settle();

    next();
    push("abort_lu_gone", K_CTL_A, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    // ---- priority of load-use over I-miss; plain I-miss; JalD ----
    next();
    drive_load_use();
    ICacheMiss = 1'b1;
    push("lu_over_imiss", K_CTL_A, ctl(S_FD, FL_E, 2'b00, 2'b00));
    settle();

    next();
    ICacheMiss = 1'b1;
    push("lu_bubble_over_imiss", K_CTL_A, ctl(S_FD, FL_E, 2'b00, 2'b00));
    settle();

    next();
    ICacheMiss = 1'b1;
    push("imiss_alone", K_CTL_A, ctl(S_F, FL_D, 2'b00, 2'b00));
    settle();

    next();
    JalD = 1'b1;
    push("jald_alone", K_CTL_A, ctl(S_NONE, FL_D, 2'b00, 2'b00));
    settle();

    // ---- interlock mode ----
    pulse_reset();

    next();
    RdM = 5'd3; RegWriteM = 3'd1; Rs2D = 5'd3; RegReadD = 2'b01;
    push("ilk_raw_m", K_CTL_B, ctl(S_FD, FL_E, 2'b00, 2'b00));
    push("fwd_mode_no_stall_m", K_CTL_A, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    next();
    RdW = 5'd3; RegWriteW = 3'd1; Rs2D = 5'd3; RegReadD = 2'b01;
    RegReadE = 2'b11; Rs1E = 5'd3; Rs2E = 5'd3;
    push("ilk_raw_w", K_CTL_B, ctl(S_FD, FL_E, 2'b00, 2'b00));
    push("fwd_mode_both_w", K_CTL_A, ctl(S_NONE, S_NONE, 2'b01, 2'b01));
    settle();

    next();
    Rs2D = 5'd3; RegReadD = 2'b01; RegReadE = 2'b11; Rs1E = 5'd3; Rs2E = 5'd3;
    push("ilk_retired", K_CTL_B, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    next();
    RdE = 5'd4; RegWriteE = 3'd1; Rs1D = 5'd4; RegReadD = 2'b10;
    push("ilk_raw_e", K_CTL_B, ctl(S_FD, FL_E, 2'b00, 2'b00));
    settle();

    next();
    RdM = 5'd3; RegWriteM = 3'd1; Rs1D = 5'd1; Rs2D = 5'd3; RegReadD = 2'b10;
    push("ilk_unused_rs2", K_CTL_B, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    next();
    RdE = 5'd0; RegWriteE = 3'd1; Rs1D = 5'd0; RegReadD = 2'b10;
    push("ilk_x0", K_CTL_B, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    next();
    MemToRegE = 1'b1; RdE = 5'd6; RegWriteE = 3'd1; Rs1D = 5'd6; RegReadD = 2'b10;
    push("lu1_detect", K_CTL_B, ctl(S_FD, FL_E, 2'b00, 2'b00));
    settle();

    next();
    push("lu1_single_bubble", K_CTL_B, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    settle();

    // ---- stall counter: exact count and saturation ----
    pulse_reset();

    for (int i = 0; i < 259; i++) begin
      next();
      DCacheMiss = 1'b1;
      if (i == 5)   push_cnt("cnt_after_5", 8'd5);
      if (i == 255) push_cnt("cnt_reaches_max", 8'd255);
      if (i == 258) push_cnt("cnt_saturated", 8'd255);
      settle();
    end

    next();
    push_cnt("cnt_held", 8'd255);
    settle();

    // ---- reset in the middle of a miss with a redirect pending ----
    next();
    BranchE = 1'b1; ICacheMiss = 1'b1;
    push("pre_reset_redir", K_CTL_A, ctl(S_NONE, FL_DE, 2'b00, 2'b00));
    settle();

    next();
    ICacheMiss = 1'b1; DCacheMiss = 1'b1;
    push("pre_reset_dmiss", K_CTL_A, ctl(S_ALL, S_NONE, 2'b00, 2'b00));
    settle();

    @(negedge clk);
    rst_n = 1'b0;
    push("midmiss_reset_ctl", K_CTL_A, ctl(S_NONE, FL_ALL, 2'b00, 2'b00));
    push_cnt("midmiss_reset_cnt", 8'd0);
    settle();

    next();
    rst_n = 1'b1;
    push("no_pend_after_reset", K_CTL_A, ctl(S_NONE, S_NONE, 2'b00, 2'b00));
    push_cnt("cnt_zero_after_reset", 8'd0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
